aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Control FSM for the AES-128 decryption datapath.
- Drives the round counter's increment and clear inputs and consumes the counter's 5-bit round count.
- Sequences the inverse-cipher steps (AddRoundKey, InvShiftRows, InvSubBytes, column-serial InvMixColumns), and issues the round-key index plus a state-register write enable per step.
- Sits between the top-level START/DONE interface and the datapath step muxes.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; the final round has no InvMixColumns.
- NUM_COLS, 4, state columns processed serially by InvMixColumns, one per cycle.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  level request to begin one decryption.
- round_count  input  5  current round from the round counter.
- round_inc  output  1  increment pulse to the round counter.
- round_clr  output  1  synchronous clear to the round counter.
- step_sel  output  3  0=NOP, 1=AddRoundKey, 2=InvShiftRows, 3=InvSubBytes, 4=InvMixColumns.
- col_sel  output  2  InvMixColumns column index.
- key_idx  output  4  round-key word-group index into the expanded schedule.
- state_we  output  1  load datapath state register with step result.
- BUSY  output  1  high while a decryption is in progress.
- DONE  output  1  decryption complete; plaintext valid.

Behaviour:
- Reset is asynchronous (RESET_N=0) and forces state IDLE, col counter 0. Outputs in IDLE are: round_inc=0, round_clr=1, step_sel=0, col_sel=0, key_idx=0, state_we=0, BUSY=0, DONE=0.
- Moore outputs are decoded from state only, except key_idx = NUM_ROUNDS - round_count (4-bit, combinational).
- States:
  - IDLE: round_clr=1. Go to INIT_ARK when START=1.
  - INIT_ARK: step_sel=1, state_we=1, round_inc=1. Go to ISR.
  - ISR: step_sel=2, state_we=1. Go to ISB.
  - ISB: step_sel=3, state_we=1. Go to ARK.
  - ARK: step_sel=1, state_we=1. Go to IMC.
  - IMC: step_sel=4, state_we=1, col_sel=col counter. The col counter increments each cycle.
    - On col=NUM_COLS-1: round_inc=1 and col resets to 0.
    - Next state is ISR if round_count < NUM_ROUNDS-1; else F_ISR.
    - The compare uses the pre-increment round_count value.
  - F_ISR: step_sel=2, state_we=1. Go to F_ISB.
  - F_ISB: step_sel=3, state_we=1. Go to F_ARK.
  - F_ARK: step_sel=1, state_we=1. Go to DONE.
  - DONE: DONE=1, BUSY=0, round_clr=1. Go to IDLE when START=0, else hold.
- BUSY=1 in every state except IDLE and DONE.
- Round/key mapping:
  - INIT_ARK sees round_count=0, so key_idx=10.
  - Main rounds r=1..9 see key_idx=10-r.
  - Final steps see round_count=10, so key_idx=0.
- Latency: START sampled in IDLE gives the following cycle counts.
  - 1 (INIT_ARK) + 9×7 (main) + 3 (final) = 67 BUSY cycles.
  - DONE rises on cycle 68 after the START edge.
- round_inc count per run: exactly 1 + 9 = 10 pulses; the counter ends at 10 and never wraps mid-run.
- START held high through DONE: no restart; a new run requires START low for ≥1 cycle. START toggling while BUSY is ignored.
- Mid-operation reset: asynchronous return to IDLE within the same cycle. The outputs immediately take reset values, so no partial state_we is issued. The round counter is cleared via round_clr on the next edge.
- round_count > 10 in IMC (corrupt input): treat as ≥9 and exit to F_ISR; do not hang.
- Unreachable state encodings decode to IDLE.

Test Plan:
- Reset: hold RESET_N=0 mid-clock → BUSY=0, DONE=0, state_we=0, round_clr=1 without waiting for an edge. Release → remains IDLE.
- Full run (bench models round counter 0..10): pulse START → step_sel sequence 1,{2,3,1,4,4,4,4}×9,2,3,1. col_sel 0..3 within each IMC group. key_idx 10,9..1 (each held 7 cycles),0,0,0. DONE at cycle 68.
- round_inc audit: count pulses over a run → exactly 10, aligned with INIT_ARK and each IMC col=3 cycle.
- START held high after DONE → DONE stays 1 for 20 cycles, no BUSY. Drop START → IDLE next cycle. Raise again → second run completes identically.
- Reset asserted at main round 5, IMC col 2 → immediate IDLE outputs. Subsequent START yields a clean 67-cycle run from key_idx=10.
- Forced round_count=15 during first IMC col 3 → next state F_ISR, then F_ISB, F_ARK, DONE; no lockup.

Source files
------------

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_sequencer
// Brief    : Control FSM stepping the AES-128 inverse cipher through its
//            rounds with a column-serial InvMixColumns.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_sequencer #(
   parameter int NUM_ROUNDS = 10,
   parameter int NUM_COLS   = 4
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       START,
   input  logic [4:0] round_count,
   output logic       round_inc,
   output logic       round_clr,
   output logic [2:0] step_sel,
   output logic [1:0] col_sel,
   output logic [3:0] key_idx,
   output logic       state_we,
   output logic       BUSY,
   output logic       DONE
);

   localparam logic [2:0] STEP_NOP = 3'd0;
   localparam logic [2:0] STEP_ARK = 3'd1;
   localparam logic [2:0] STEP_ISR = 3'd2;
   localparam logic [2:0] STEP_ISB = 3'd3;
   localparam logic [2:0] STEP_IMC = 3'd4;

   localparam logic [1:0] LAST_COL    = 2'(NUM_COLS - 1);
   localparam logic [4:0] LAST_MAIN   = 5'(NUM_ROUNDS - 1);
   localparam logic [3:0] ROUNDS_KEY  = 4'(NUM_ROUNDS);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_INIT_ARK = 4'd1,
      S_ISR      = 4'd2,
      S_ISB      = 4'd3,
      S_ARK      = 4'd4,
      S_IMC      = 4'd5,
      S_F_ISR    = 4'd6,
      S_F_ISB    = 4'd7,
      S_F_ARK    = 4'd8,
      S_DONE     = 4'd9
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [1:0] col;
   logic [1:0] col_next;
   logic       busy_int;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= S_IDLE;
         col   <= 2'd0;
      end else begin
         state <= next_state;
         col   <= col_next;
      end
   end

   always_comb begin
      next_state = state;
      col_next   = 2'd0;
      round_inc  = 1'b0;
      round_clr  = 1'b0;
      step_sel   = STEP_NOP;
      col_sel    = 2'd0;
      state_we   = 1'b0;
      busy_int   = 1'b1;
      DONE       = 1'b0;

      case (state)
         S_IDLE: begin
            round_clr = 1'b1;
            busy_int  = 1'b0;
            if (START) next_state = S_INIT_ARK;
         end
         S_INIT_ARK: begin
            step_sel   = STEP_ARK;
            state_we   = 1'b1;
            round_inc  = 1'b1;
            next_state = S_ISR;
         end
         S_ISR: begin
            step_sel   = STEP_ISR;
            state_we   = 1'b1;
            next_state = S_ISB;
         end
         S_ISB: begin
            step_sel   = STEP_ISB;
            state_we   = 1'b1;
            next_state = S_ARK;
         end
         S_ARK: begin
            step_sel   = STEP_ARK;
            state_we   = 1'b1;
            next_state = S_IMC;
         end
         S_IMC: begin
            step_sel = STEP_IMC;
            state_we = 1'b1;
            col_sel  = col;
            if (col == LAST_COL) begin
               // Decision uses the pre-increment count; corrupt values
               // above the last main round also fall through to the final round.
               round_inc  = 1'b1;
               next_state = (round_count < LAST_MAIN) ? S_ISR : S_F_ISR;
            end else begin
               col_next = col + 2'd1;
            end
         end
         S_F_ISR: begin
            step_sel   = STEP_ISR;
            state_we   = 1'b1;
            next_state = S_F_ISB;
         end
         S_F_ISB: begin
            step_sel   = STEP_ISB;
            state_we   = 1'b1;
            next_state = S_F_ARK;
         end
         S_F_ARK: begin
            step_sel   = STEP_ARK;
            state_we   = 1'b1;
            next_state = S_DONE;
         end
         S_DONE: begin
            DONE      = 1'b1;
            busy_int  = 1'b0;
            round_clr = 1'b1;
            if (!START) next_state = S_IDLE;
         end
         default: begin
            round_clr  = 1'b1;
            busy_int   = 1'b0;
            next_state = S_IDLE;
         end
      endcase
   end

   // Key schedule is walked backwards; index is parked at 0 when idle.
   assign key_idx = busy_int ? (ROUNDS_KEY - round_count[3:0]) : 4'd0;
   assign BUSY    = busy_int;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_sequencer
// Brief    : Directed self-checking bench for aes_round_sequencer with a
//            behavioural round counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_sequencer;

   logic       CLK;
   logic       RESET_N;
   logic       START;
   logic [4:0] round_count;
   logic       round_inc;
   logic       round_clr;
   logic [2:0] step_sel;
   logic [1:0] col_sel;
   logic [3:0] key_idx;
   logic       state_we;
   logic       BUSY;
   logic       DONE;

   logic [4:0]  cnt;
   logic        force_rc;
   int          inc_cnt;
   int          checks;
   int          errors;
   int          base;
   logic [13:0] outs;

   localparam logic [13:0] V_IDLE = 14'h0004;
   localparam logic [13:0] V_DONE = 14'h0005;

   aes_round_sequencer #(.NUM_ROUNDS(10), .NUM_COLS(4)) dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .START      (START),
      .round_count(round_count),
      .round_inc  (round_inc),
      .round_clr  (round_clr),
      .step_sel   (step_sel),
      .col_sel    (col_sel),
      .key_idx    (key_idx),
      .state_we   (state_we),
      .BUSY       (BUSY),
      .DONE       (DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // External round counter driven by the sequencer's clear/increment.
   initial cnt = 5'd0;
   initial inc_cnt = 0;
   always @(posedge CLK) begin
      if (round_clr) cnt <= 5'd0;
      else if (round_inc) cnt <= cnt + 5'd1;
      if (round_inc) inc_cnt <= inc_cnt + 1;
   end
   assign round_count = force_rc ? 5'd15 : cnt;

   assign outs = {step_sel, col_sel, key_idx, state_we, round_inc, round_clr, BUSY, DONE};

   // Expected output vector for busy cycle n (1 = INIT_ARK ... 67 = F_ARK).
   function automatic logic [13:0] exp_busy(input int n);
      int m, r, p, f;
      logic [2:0] st;
      logic [1:0] cl;
      logic [3:0] k;
      logic       inc;
      st = 3'd0; cl = 2'd0; k = 4'd0; inc = 1'b0;
      if (n == 1) begin
         st = 3'd1; k = 4'd10; inc = 1'b1;
      end else begin
         m = n - 2;
         if (m < 63) begin
            r = m / 7 + 1;
            p = m % 7;
            case (p)
               0:       st = 3'd2;
               1:       st = 3'd3;
               2:       st = 3'd1;
               default: st = 3'd4;
            endcase
            if (p >= 3) cl = 2'(p - 3);
            k   = 4'(10 - r);
            inc = (p == 6);
         end else begin
            f = m - 63;
            case (f)
               0:       st = 3'd2;
               1:       st = 3'd3;
               default: st = 3'd1;
            endcase
         end
      end
      return {st, cl, k, 1'b1, inc, 1'b0, 1'b1, 1'b0};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_cycles(input int run_id, input int first, input int last);
      for (int n = first; n <= last; n++) begin
         check($sformatf("run%0d_cyc%0d", run_id, n), 32'(outs), 32'(exp_busy(n)));
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      RESET_N  = 1'b0;
      START    = 1'b0;
      force_rc = 1'b0;

      // Asynchronous reset takes effect before any clock edge.
      #2;
      check("reset_async", 32'(outs), 32'(V_IDLE));
      tick();
      tick();
      #2 RESET_N = 1'b1;
      tick();
      check("reset_release_idle", 32'(outs), 32'(V_IDLE));
      check("reset_cnt_clear", 32'(cnt), 32'd0);

      // Run 1: full decryption.
      base  = inc_cnt;
      START = 1'b1;
      tick();
      run_cycles(1, 1, 67);
      check("run1_done", 32'(outs), 32'(V_DONE));
      check("run1_inc_pulses", 32'(inc_cnt - base), 32'd10);
      check("run1_cnt_final", 32'(cnt), 32'd10);

      // START held: DONE persists, no restart.
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("hold_done_%0d", i), 32'(outs), 32'(V_DONE));
      end
      START = 1'b0;
      tick();
      check("drop_start_idle", 32'(outs), 32'(V_IDLE));

      // Run 2: identical second run.
      base  = inc_cnt;
      START = 1'b1;
      tick();
      run_cycles(2, 1, 67);
      check("run2_done", 32'(outs), 32'(V_DONE));
      check("run2_inc_pulses", 32'(inc_cnt - base), 32'd10);
      START = 1'b0;
      tick();
      check("run2_idle", 32'(outs), 32'(V_IDLE));

      // Run 3: reset in main round 5, IMC column 2.
      START = 1'b1;
      tick();
      run_cycles(3, 1, 34);
      check("run3_r5_col2", 32'(outs), 32'(exp_busy(35)));
      #2 RESET_N = 1'b0;
      #1;
      check("run3_reset_immediate", 32'(outs), 32'(V_IDLE));
      START = 1'b0;
      tick();
      check("run3_reset_held", 32'(outs), 32'(V_IDLE));
      check("run3_cnt_cleared", 32'(cnt), 32'd0);
      #3 RESET_N = 1'b1;
      tick();
      check("run3_release_idle", 32'(outs), 32'(V_IDLE));

      // Run 4: clean run after the mid-run reset.
      base  = inc_cnt;
      START = 1'b1;
      tick();
      run_cycles(4, 1, 67);
      check("run4_done", 32'(outs), 32'(V_DONE));
      check("run4_inc_pulses", 32'(inc_cnt - base), 32'd10);
      START = 1'b0;
      tick();

      // Run 5: corrupt round_count=15 at first IMC column 3.
      START = 1'b1;
      tick();
      run_cycles(5, 1, 7);
      force_rc = 1'b1;
      #1;
      check("run5_corrupt_imc3", 32'(outs), 32'({3'd4, 2'd3, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}));
      tick();
      force_rc = 1'b0;
      check("run5_f_isr", 32'({step_sel, state_we, BUSY}), 32'({3'd2, 1'b1, 1'b1}));
      tick();
      check("run5_f_isb", 32'({step_sel, state_we, BUSY}), 32'({3'd3, 1'b1, 1'b1}));
      tick();
      check("run5_f_ark", 32'({step_sel, state_we, BUSY}), 32'({3'd1, 1'b1, 1'b1}));
      tick();
      check("run5_done", 32'(outs), 32'(V_DONE));
      START = 1'b0;
      tick();
      check("run5_idle", 32'(outs), 32'(V_IDLE));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
